reg_file_dump: RTL

- Architectural integer register file for the single-cycle RISC-V core.
- Drives both ALU operand sources: RD1 goes to SrcA, RD2 goes to the ALUSrc operand mux.
- Accepts the writeback result on WD3.
- Adds a sequential debug dump port: a valid/ready streaming FSM that emits every register in order for bench and debug inspection.

---
 rtl/reg_file_dump.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/reg_file_dump.sv
// ---------------------------------------------------------------------------
// reg_file_dump
//
// Architectural integer register file for the single-cycle RISC-V core, with
// a streaming debug dump port that emits every register in index order.
//
// Ports:
//   clk        core clock, all state changes on its rising edge
//   rst_n      asynchronous active-low reset
//   A1, A2     read indices (rs1, rs2); RD1/RD2 are combinational
//   A3, WE3,   write index (rd), write enable and writeback data
//   WD3
//   RD1        read data 1, feeds ALU SrcA
//   RD2        read data 2, feeds the ALUSrc operand mux
//   DumpReq    starts a dump, only looked at while idle
//   DumpReady  consumer accepts the current beat
//   DumpValid  current beat is valid
//   DumpAddr   register index of the current beat
//   DumpData   snapshot of register DumpAddr
//   DumpBusy   high while a dump is streaming or finishing
//   DumpDone   one-cycle pulse after the last beat is accepted
//
// Optional feature macro: REGFILE_BYPASS_EN
//   When defined, a read that collides with a same-cycle write to the same
//   non-zero index returns WD3 (write-first). When undefined the stored value
//   is returned. The dump port always shows pre-edge contents either way.
// ---------------------------------------------------------------------------
module reg_file_dump #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [ADDR_WIDTH-1:0] A1,
   input  logic [ADDR_WIDTH-1:0] A2,
   input  logic [ADDR_WIDTH-1:0] A3,
   input  logic                  WE3,
   input  logic [DATA_WIDTH-1:0] WD3,
   output logic [DATA_WIDTH-1:0] RD1,
   output logic [DATA_WIDTH-1:0] RD2,
   input  logic                  DumpReq,
   input  logic                  DumpReady,
   output logic                  DumpValid,
   output logic [ADDR_WIDTH-1:0] DumpAddr,
   output logic [DATA_WIDTH-1:0] DumpData,
   output logic                  DumpBusy,
   output logic                  DumpDone
);

   localparam int NUM_REGS = 2 ** ADDR_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(NUM_REGS - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      DONE = 2'd2
   } state_t;

   logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
   logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] idx_q, idx_d;
   logic [ADDR_WIDTH-1:0] idx_inc;
   logic                  valid_q, valid_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;

   // Writes to x0 are dropped so index 0 stays hard-wired to zero.
   always_comb begin
      regs_d = regs_q;
      if (WE3 && (A3 != '0)) begin
         regs_d[A3] = WD3;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         regs_q <= regs_d;
      end
   end

   // Read ports; the collision forward only exists in the bypass build.
   always_comb begin
      RD1 = (A1 == '0) ? '0 : regs_q[A1];
      RD2 = (A2 == '0) ? '0 : regs_q[A2];
`ifdef REGFILE_BYPASS_EN
      if (WE3 && (A3 == A1) && (A1 != '0)) begin
         RD1 = WD3;
      end
      if (WE3 && (A3 == A2) && (A2 != '0)) begin
         RD2 = WD3;
      end
`endif
   end

   assign idx_inc = idx_q + ADDR_WIDTH'(1);

   // Dump sequencer. DumpData is loaded from regs_q (pre-edge contents) only
   // when a beat is presented, so it is a snapshot that later writes cannot
   // disturb. Leaving SEND clears index and data so both read 0 while idle.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      valid_d = valid_q;
      data_d  = data_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (DumpReq) begin
               state_d = SEND;
               idx_d   = '0;
               valid_d = 1'b1;
               data_d  = regs_q[0];
               busy_d  = 1'b1;
            end
         end
         SEND: begin
            if (valid_q && DumpReady) begin
               if (idx_q == LAST) begin
                  state_d = DONE;
                  idx_d   = '0;
                  valid_d = 1'b0;
                  data_d  = '0;
                  done_d  = 1'b1;
               end else begin
                  idx_d  = idx_inc;
                  data_d = regs_q[idx_inc];
               end
            end
         end
         DONE: begin
            state_d = IDLE;
            idx_d   = '0;
            valid_d = 1'b0;
            data_d  = '0;
            busy_d  = 1'b0;
         end
         default: begin
            state_d = IDLE;
            idx_d   = '0;
            valid_d = 1'b0;
            data_d  = '0;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         valid_q <= 1'b0;
         data_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         valid_q <= valid_d;
         data_q  <= data_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign DumpValid = valid_q;
   assign DumpAddr  = idx_q;
   assign DumpData  = data_q;
   assign DumpBusy  = busy_q;
   assign DumpDone  = done_q;

endmodule
